// File: rtl/mux4_scanner_if.sv
// mux4_scanner_if: channel bus between a 4-to-1 collector and its user.
//   en, auto, s, d        : controls and channel lines into the collector
//   y, s_out, valid       : registered selected value, its channel, strobe
//   frame, sample         : frame-complete pulse and last complete frame word
// master modport is the user side, slave modport is the collector side.
interface mux4_scanner_if;
  logic       en;
  logic       auto;
  logic [1:0] s;
  logic [3:0] d;
  logic       y;
  logic [1:0] s_out;
  logic       valid;
  logic       frame;
  logic [3:0] sample;

  modport master (
    output en, auto, s, d,
    input  y, s_out, valid, frame, sample
  );

  modport slave (
    input  en, auto, s, d,
    output y, s_out, valid, frame, sample
  );
endinterface

// File: rtl/mux4_scanner.sv
// mux4_scanner: registered 4-to-1 collector with manual and round-robin modes.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   bus   : mux4_scanner_if.slave
//           en=0 idles the block; auto=0 selects d[s] every cycle;
//           auto=1 scans channels 0..3, DWELL cycles each, sampling each
//           channel on the last cycle of its dwell and publishing the
//           4-bit frame on sample with a one-cycle frame pulse.
// All outputs are registered; no input reaches an output combinationally.
module mux4_scanner #(
  parameter int unsigned DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux4_scanner_if.slave  bus
);

  localparam int unsigned   CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t        state;
  logic [1:0]    ch;
  logic [CW-1:0] cnt;
  logic [2:0]    shadow;
  logic          y_r;
  logic [1:0]    s_out_r;
  logic          valid_r;
  logic          frame_r;
  logic [3:0]    sample_r;
  logic          last;

  assign last       = (cnt == LAST);
  assign bus.y      = y_r;
  assign bus.s_out  = s_out_r;
  assign bus.valid  = valid_r;
  assign bus.frame  = frame_r;
  assign bus.sample = sample_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch       <= '0;
      cnt      <= '0;
      shadow   <= '0;
      y_r      <= 1'b0;
      s_out_r  <= '0;
      valid_r  <= 1'b0;
      frame_r  <= 1'b0;
      sample_r <= '0;
    end else if (!bus.en) begin
      state   <= IDLE;
      y_r     <= 1'b0;
      s_out_r <= '0;
      valid_r <= 1'b0;
      frame_r <= 1'b0;
    end else if (!bus.auto) begin
      state   <= MANUAL;
      y_r     <= bus.d[bus.s];
      s_out_r <= bus.s;
      valid_r <= 1'b1;
      frame_r <= 1'b0;
    end else if (state != SCAN) begin
      // Entry edge: restart the frame at channel 0; any partial shadow
      // bits from an aborted scan are overwritten before they are used.
      state   <= SCAN;
      ch      <= '0;
      cnt     <= '0;
      y_r     <= 1'b0;
      s_out_r <= '0;
      valid_r <= 1'b0;
      frame_r <= 1'b0;
    end else begin
      y_r     <= bus.d[ch];
      s_out_r <= ch;
      valid_r <= last;
      if (last) begin
        cnt <= '0;
        ch  <= ch + 2'd1;
        if (ch == 2'd3) begin
          // Channel 3 goes straight into the frame word; it never needs
          // a shadow slot.
          sample_r <= {bus.d[3], shadow};
          frame_r  <= 1'b1;
        end else begin
          shadow[ch] <= bus.d[ch];
          frame_r    <= 1'b0;
        end
      end else begin
        cnt     <= cnt + 1'b1;
        frame_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux4_scanner.sv
// tb_mux4_scanner: directed bench for mux4_scanner with DWELL=4 and DWELL=1
// instances. Each step drives inputs, queues the expected registered output
// word {y, s_out, valid, frame, sample}, and compares it after the next edge.
module tb_mux4_scanner;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mux4_scanner_if bus4();
  mux4_scanner_if bus1();

  mux4_scanner #(.DWELL(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));
  mux4_scanner #(.DWELL(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    bit         which;
    logic [8:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [8:0] pack(input logic y, input logic [1:0] so,
                                      input logic v, input logic f,
                                      input logic [3:0] smp);
    return {y, so, v, f, smp};
  endfunction

  task automatic tick(input bit which, input logic [8:0] e, input string tag);
    exp_t       x;
    logic [8:0] act;
    x.which = which;
    x.val   = e;
    x.tag   = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    if (x.which)
      act = {bus1.y, bus1.s_out, bus1.valid, bus1.frame, bus1.sample};
    else
      act = {bus4.y, bus4.s_out, bus4.valid, bus4.frame, bus4.sample};
    checks++;
    assert (act === x.val) else begin
      errors++;
      $error("FAIL %s: observed {y,s_out,valid,frame,sample}=%b expected %b",
             x.tag, act, x.val);
    end
  endtask

  // Drives nk scan cycles of the DWELL=4 instance from the start of a frame.
  // With glitch set, d[1] alternates 0,1,0,1 across the channel-1 dwell.
  task automatic run_frame(input logic [3:0] base, input bit glitch,
                           input logic [3:0] old_s, input logic [3:0] new_s,
                           input int unsigned nk, input string tag);
    logic [3:0]  dv;
    int unsigned c;
    for (int unsigned k = 1; k <= nk; k++) begin
      c  = (k - 1) / 4;
      dv = base;
      if (glitch && c == 1) dv[1] = (k % 2 == 0);
      bus4.d = dv;
      tick(1'b0, pack(dv[c], 2'(c), (k % 4 == 0), (k == 16),
                      (k == 16) ? new_s : old_s),
           $sformatf("%s_k%0d", tag, k));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  man_y;
    logic [3:0]  dv;
    logic [3:0]  bits;
    logic [3:0]  smp;
    int unsigned c;

    rst       = 1'b1;
    bus4.en   = 1'b1;
    bus4.auto = 1'b1;
    bus4.s    = 2'd0;
    bus4.d    = 4'b1111;
    bus1.en   = 1'b0;
    bus1.auto = 1'b0;
    bus1.s    = 2'd0;
    bus1.d    = 4'b0000;

    // Reset with scan requested: outputs stay zero during and just after.
    tick(1'b0, '0, "rst_1");
    tick(1'b0, '0, "rst_2");
    rst = 1'b0;
    tick(1'b0, '0, "post_rst");
    bus4.en = 1'b0;
    tick(1'b0, '0, "idle");

    // Manual select.
    bus4.en   = 1'b1;
    bus4.auto = 1'b0;
    bus4.d    = 4'b0100;
    man_y     = 4'b0100;
    for (int unsigned i = 0; i < 4; i++) begin
      bus4.s = 2'(i);
      tick(1'b0, pack(man_y[i], 2'(i), 1'b1, 1'b0, 4'b0000),
           $sformatf("manual_s%0d", i));
    end

    // Auto scan with constant data, two full frames.
    bus4.auto = 1'b1;
    bus4.d    = 4'b1010;
    tick(1'b0, '0, "entry");
    run_frame(4'b1010, 1'b0, 4'b0000, 4'b1010, 16, "frame1");
    run_frame(4'b1010, 1'b0, 4'b1010, 4'b1010, 16, "frame2");

    // Channel 1 only counts at the last cycle of its dwell.
    run_frame(4'b0001, 1'b1, 4'b1010, 4'b0011, 16, "glitch");

    // Abort after two channels sampled, then restart from channel 0.
    run_frame(4'b0101, 1'b0, 4'b0011, 4'b0011, 8, "partial");
    bus4.en = 1'b0;
    tick(1'b0, pack(1'b0, 2'd0, 1'b0, 1'b0, 4'b0011), "abort_idle");
    bus4.en = 1'b1;
    tick(1'b0, pack(1'b0, 2'd0, 1'b0, 1'b0, 4'b0011), "reentry");
    run_frame(4'b1100, 1'b0, 4'b0011, 4'b1100, 16, "restart");

    // Manual after scan: sample is held.
    bus4.auto = 1'b0;
    bus4.s    = 2'd2;
    bus4.d    = 4'b1100;
    tick(1'b0, pack(1'b1, 2'd2, 1'b1, 1'b0, 4'b1100), "manual_hold");
    bus4.en = 1'b0;

    // DWELL=1: strobe every scan cycle, frame every fourth.
    bus1.en   = 1'b1;
    bus1.auto = 1'b1;
    bus1.d    = 4'b0000;
    tick(1'b1, '0, "d1_entry");
    bits = 4'b0000;
    smp  = 4'b0000;
    for (int unsigned k = 1; k <= 12; k++) begin
      dv      = 4'($urandom);
      c       = (k - 1) % 4;
      bus1.d  = dv;
      bits[c] = dv[c];
      if (k % 4 == 0) smp = bits;
      tick(1'b1, pack(dv[c], 2'(c), 1'b1, (k % 4 == 0), smp),
           $sformatf("d1_k%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
